fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single write port of the async FIFO (fifo1)
//  between NREQ requesters in the write clock domain. Drives winc/wdata
//  directly, honours wfull, and holds a grant for bursts of up to BURST_LEN
//  beats before rotating. Sits between requesters and fifo1 on wclk.
// PARAMETERS
//  DSIZE     8  data width per beat; must equal fifo1 data width
//  NREQ      4  number of requesters, >=1
//  BURST_LEN 4  max beats per grant before forced rotation, >=1
//  IDW       2  grant id width = max(1,$clog2(NREQ)); derived, do not override
// PORTS
//  wclk       in   1           write-domain clock, rising edge
//  wrst_n     in   1           async active-low reset
//  req_valid  in   NREQ        per-requester beat valid
//  req_data   in   NREQ*DSIZE  requester i data in [i*DSIZE +: DSIZE]
//  req_ready  out  NREQ        beat of requester i accepted this cycle
//  wfull      in   1           fifo1 full flag (wclk domain)
//  winc       out  1           write strobe to fifo1
//  wdata      out  DSIZE       write data to fifo1
//  grant_vld  out  1           a grant is held (state GRANT)
//  grant_id   out  IDW         index of current grantee; 0 when idle
// BEHAVIOUR
//  - Handshake: valid/ready per requester. Beat i transfers on the wclk edge
//    where req_valid[i] & req_ready[i]. Requester holds data stable until then.
//  - Combinational outputs, GRANT state, grantee g:
//    req_ready[g] = req_valid[g] & ~wfull; all other req_ready = 0.
//    winc = req_ready[g]; wdata = req_data[g]. Outside GRANT: winc=0,
//    all req_ready=0, wdata=0. winc is never high while wfull is high.
//  - Registered state: state{IDLE,GRANT}, g, rr_ptr (IDW), beat_cnt.
//  - Arbitration (pick): first i with req_valid[i], scanning rr_ptr,
//    rr_ptr+1, ... modulo NREQ.
//  - IDLE: if any req_valid, next state GRANT, g = pick. Else stay.
//    Latency: req_valid rises at edge N -> first possible beat at edge N+1.
//  - GRANT ends at an edge when (a) req_valid[g]==0, or (b) a beat is accepted
//    with beat_cnt==BURST_LEN-1. On end: rr_ptr = (g+1) mod NREQ; beat_cnt=0;
//    the next grantee is picked from the new rr_ptr in the same edge.
//    If one is found, go directly to GRANT with no idle cycle. Else go to IDLE.
//    The exiting grantee is eligible again, but at lowest priority.
//  - beat_cnt increments only on accepted beats. It holds while wfull=1.
//    The grant is held through any wfull stall (no timeout).
//  - wfull asserted with valid pending: no beat, no rotation, state unchanged.
//  - NREQ=1: rr_ptr is always 0; single requester is re-granted after each end.
//  - BURST_LEN=1: rotation after every accepted beat.
//  - Reset (async, any time incl. mid-burst): state=IDLE, g=0, rr_ptr=0,
//    beat_cnt=0. Outputs immediately winc=0, req_ready=0, wdata=0,
//    grant_vld=0, grant_id=0. An in-flight beat is not written; the requester
//    must re-present it.
// TESTING
//  1 Reset: assert wrst_n=0 mid-burst -> winc/req_ready/grant_vld drop at once;
//    after release, first grant goes to lowest valid index from 0.
//  2 Single req: req_valid=0001, data 1..8, wfull=0 -> IDLE 1 cycle, then
//    winc every cycle; grant_id=0 re-granted after each 4 beats, no gap.
//  3 All valid: req_valid=1111, BURST_LEN=4 -> grant order 0,1,2,3,0.
//    Each grant gives exactly 4 winc; fifo1 reads back in that order.
//  4 Backpressure: force wfull=1 after beat 2 of req 1 for 5 cycles ->
//    winc=0, req_ready=0, grant_id stays 1; then beats 3,4 complete, rotate to 2.
//  5 Early release: req 2 drops valid after 1 beat with req 0 valid ->
//    next edge grant_id=0 (wraps), rr_ptr=3.
//  6 End-to-end with fifo1 (wclk 20ns, rclk 100ns): 3 requesters, 32 beats each ->
//    no loss/duplication, no winc while wfull, per-requester order preserved.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares the single write port of fifo1 between NREQ
// requesters in the wclk domain, holding each grant for up to BURST_LEN beats.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 4,
    parameter int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic                  grant_vld,
    output logic [IDW-1:0]        grant_id
);

    localparam int            CW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  g_q, g_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic [IDW:0]    pick_rr;
    logic [IDW:0]    pick_next;
    logic [IDW-1:0]  next_ptr;
    logic            accept;
    logic            grant_end;

    // Returns {found, index} of the first valid requester scanning from ptr.
    function automatic logic [IDW:0] pick(input logic [NREQ-1:0] v,
                                          input logic [IDW-1:0]  ptr);
        logic           found;
        logic [IDW-1:0] idx;
        int             j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && v[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        next_ptr  = IDW'((int'(g_q) + 1) % NREQ);
        pick_rr   = pick(req_valid, rr_ptr_q);
        pick_next = pick(req_valid, next_ptr);
    end

    always_comb begin
        req_ready  = '0;
        winc       = 1'b0;
        wdata      = '0;
        accept     = 1'b0;
        grant_end  = 1'b0;
        state_d    = state_q;
        g_d        = g_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_rr[IDW]) begin
                    state_d = GRANT;
                    g_d     = pick_rr[IDW-1:0];
                end
            end
            GRANT: begin
                accept         = req_valid[g_q] & ~wfull;
                req_ready[g_q] = accept;
                winc           = accept;
                wdata          = req_data[g_q*DSIZE +: DSIZE];
                grant_end      = ~req_valid[g_q] | (accept & (beat_cnt_q == LAST_BEAT));
                // The exiting grantee sits last in the scan from g+1, so it
                // can be re-granted only if nobody else is waiting.
                if (grant_end) begin
                    rr_ptr_d   = next_ptr;
                    beat_cnt_d = '0;
                    if (pick_next[IDW]) begin
                        g_d = pick_next[IDW-1:0];
                    end else begin
                        state_d = IDLE;
                        g_d     = '0;
                    end
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= IDLE;
            g_q        <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant_vld = (state_q == GRANT);
    assign grant_id  = grant_vld ? g_q : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter: a rotating-priority-list
// reference model predicts every cycle's outputs, a monitor checks them.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int DSIZE     = 8;
    localparam int NREQ      = 4;
    localparam int BURST_LEN = 4;
    localparam int IDW       = 2;

    logic                  wclk = 1'b0;
    logic                  wrst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  grant_vld;
    logic [IDW-1:0]        grant_id;

    always #10 wclk = ~wclk;

    fifo_wr_arbiter #(
        .DSIZE(DSIZE), .NREQ(NREQ), .BURST_LEN(BURST_LEN)
    ) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .wfull(wfull), .winc(winc), .wdata(wdata),
        .grant_vld(grant_vld), .grant_id(grant_id)
    );

    typedef struct packed {
        logic             gv;
        logic [IDW-1:0]   gid;
        logic             winc;
        logic [NREQ-1:0]  rdy;
        logic [DSIZE-1:0] wd;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: current owner (-1 = none), beats used, priority list.
    int              owner;
    int              used;
    int              order[$];
    int              seq[NREQ];
    logic [NREQ-1:0] cur_v;
    logic            cur_f;

    function automatic logic [DSIZE-1:0] mk(input int i, input int s);
        return DSIZE'((i << 6) | (s & 63));
    endfunction

    function automatic void model_reset();
        owner = -1;
        used  = 0;
        order.delete();
        for (int i = 0; i < NREQ; i++) order.push_back(i);
    endfunction

    function automatic int pick_order(input logic [NREQ-1:0] v);
        foreach (order[k]) if (v[order[k]]) return order[k];
        return -1;
    endfunction

    // Advances the model over one clock edge using the inputs held this cycle.
    function automatic void model_step();
        bit acc;
        int nxt;
        if (owner < 0) begin
            owner = pick_order(cur_v);
            used  = 0;
        end else begin
            acc = cur_v[owner] && !cur_f;
            if (acc) begin
                used++;
                seq[owner]++;
            end
            if (!cur_v[owner] || (acc && used == BURST_LEN)) begin
                nxt = (owner + 1) % NREQ;
                while (order[0] != nxt) order.push_back(order.pop_front());
                used  = 0;
                owner = pick_order(cur_v);
            end
        end
    endfunction

    function automatic obs_t expected();
        obs_t e;
        e = '0;
        if (owner >= 0) begin
            e.gv  = 1'b1;
            e.gid = IDW'(owner);
            e.wd  = mk(owner, seq[owner]);
            if (cur_v[owner] && !cur_f) begin
                e.rdy[owner] = 1'b1;
                e.winc       = 1'b1;
            end
        end
        return e;
    endfunction

    function automatic obs_t observed();
        return {grant_vld, grant_id, winc, req_ready, wdata};
    endfunction

    function automatic void check(input string name, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got gv=%0b gid=%0d winc=%0b rdy=%b wdata=%h, expected gv=%0b gid=%0d winc=%0b rdy=%b wdata=%h",
                     name, $time, got.gv, got.gid, got.winc, got.rdy, got.wd,
                     exp.gv, exp.gid, exp.winc, exp.rdy, exp.wd);
        end
    endfunction

    task automatic drive();
        req_valid = cur_v;
        wfull     = cur_f;
        for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = mk(i, seq[i]);
    endtask

    task automatic step_cycle(input logic [NREQ-1:0] v, input logic f);
        @(posedge wclk);
        model_step();
        #1;
        cur_v = v;
        cur_f = f;
        drive();
        exp_q.push_back(expected());
    endtask

    // Asynchronous reset in the middle of a cycle while all requesters are valid.
    task automatic mid_reset(input logic [NREQ-1:0] v_after);
        @(posedge wclk);
        model_step();
        #1;
        cur_v = '1;
        cur_f = 1'b0;
        drive();
        #1 wrst_n = 1'b0;
        #1 check("async_reset", observed(), '0);
        @(posedge wclk);
        #1 check("reset_hold", observed(), '0);
        cur_v = v_after;
        drive();
        #1 check("reset_hold_valid", observed(), '0);
        #2 wrst_n = 1'b1;
        model_reset();
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge wclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", observed(), e);
            end
        end
    end

    initial begin : stimulus
        wrst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) seq[i] = 1;
        model_reset();
        cur_v = '0;
        cur_f = 1'b0;
        drive();
        #5 check("reset_state", observed(), '0);
        repeat (2) @(posedge wclk);
        #3 wrst_n = 1'b1;

        // Single requester: re-granted after every burst with no gap.
        for (int c = 0; c < 12; c++) step_cycle(4'b0001, 1'b0);
        // Everyone valid: strict 0,1,2,3,0 rotation in bursts of four.
        for (int c = 0; c < 20; c++) step_cycle(4'b1111, 1'b0);
        // Backpressure stall in the middle of a burst.
        for (int c = 0; c < 24; c++) step_cycle(4'b1111, (c >= 8 && c < 13));
        // Early release by requester 2, wrapping to requester 0.
        for (int c = 0; c < 2; c++) step_cycle(4'b0000, 1'b0);
        for (int c = 0; c < 2; c++) step_cycle(4'b0100, 1'b0);
        for (int c = 0; c < 4; c++) step_cycle(4'b0001, 1'b0);
        // Reset mid-burst, then the lowest valid index wins first.
        for (int c = 0; c < 6; c++) step_cycle(4'b1111, 1'b0);
        mid_reset(4'b0110);
        for (int c = 0; c < 8; c++) step_cycle(4'b0110, 1'b0);
        // Random traffic with random backpressure.
        for (int c = 0; c < 250; c++) begin
            logic [NREQ-1:0] v;
            for (int i = 0; i < NREQ; i++) v[i] = ($urandom_range(0, 3) != 0);
            step_cycle(v, ($urandom_range(0, 4) == 0));
        end

        @(negedge wclk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
